pc_gen_ras: RTL and testbench

Parametrised program-counter generator: the next generation of the fetch-stage PC unit. Each clock it selects the next PC from one of five sources: sequential, PC-relative branch, absolute jump, call, or return. It adds a pipeline stall hold and a hardware return-address stack (RAS) for call/return. It sits at the front of the fetch stage, drives the instruction-memory address and takes control from the decode/branch logic.

---
 rtl/pc_gen_ras.sv | 150 +++++++++++++++
 tb/tb_pc_gen_ras.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pc_gen_ras.sv
// Fetch-stage PC generator: sequential, branch, jump, call and return with a circular return-address stack.
// Optional target alignment check is enabled by defining PC_ALIGN_CHK_EN.
module pc_gen_ras #(
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_VEC = ADDR_W'(32'h0000_3000),
    parameter int                 RAS_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              PcReSetN,
    input  logic              PcHold,
    input  logic [2:0]        PcSel,
    input  logic [ADDR_W-1:0] Address,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] PcPlus4,
    output logic              RasEmpty,
    output logic              RasFull,
    output logic              RasUnderflow,
    output logic              Misalign
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        SEL_SEQ    = 3'b000,
        SEL_BRANCH = 3'b001,
        SEL_JUMP   = 3'b010,
        SEL_CALL   = 3'b011,
        SEL_RET    = 3'b100
    } sel_e;

    sel_e              sel;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  top_q, top_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              underflow_q, underflow_d;
    logic              misalign_d;
    logic              push;
    logic              tgt_ok;
    logic              ras_full;
    logic              ras_empty;
    logic [ADDR_W-1:0] abs_tgt;
    logic [ADDR_W-1:0] branch_tgt;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

    assign sel        = sel_e'(PcSel);
    assign PcPlus4    = pc_q + ADDR_W'(4);
    assign abs_tgt    = {Address[ADDR_W-1:2], 2'b00};
    // The shift drops the top two offset bits; the add wraps naturally at ADDR_W.
    assign branch_tgt = pc_q + {Address[ADDR_W-3:0], 2'b00};
    assign ras_full   = (cnt_q == CNT_W'(RAS_DEPTH));
    assign ras_empty  = (cnt_q == '0);

`ifdef PC_ALIGN_CHK_EN
    logic misalign_q;
    assign tgt_ok   = (Address[1:0] == 2'b00);
    assign Misalign = misalign_q;
`else
    logic unused_align;
    assign tgt_ok       = 1'b1;
    assign unused_align = misalign_d;
    assign Misalign     = 1'b0;
`endif

    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pc_d        = pc_q;
        top_d       = top_q;
        cnt_d       = cnt_q;
        push        = 1'b0;
        underflow_d = 1'b0;
        misalign_d  = 1'b0;
        if (!PcHold) begin
            unique case (sel)
                SEL_BRANCH: pc_d = branch_tgt;
                SEL_JUMP: begin
                    if (tgt_ok) begin
                        pc_d = abs_tgt;
                    end else begin
                        pc_d       = PcPlus4;
                        misalign_d = 1'b1;
                    end
                end
                SEL_CALL: begin
                    if (tgt_ok) begin
                        pc_d  = abs_tgt;
                        push  = 1'b1;
                        top_d = top_q + PTR_W'(1);
                        // A full stack overwrites its oldest entry in place of growing.
                        if (!ras_full) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        pc_d       = PcPlus4;
                        misalign_d = 1'b1;
                    end
                end
                SEL_RET: begin
                    if (!ras_empty) begin
                        pc_d  = ras_q[top_q];
                        top_d = top_q - PTR_W'(1);
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        pc_d        = PcPlus4;
                        underflow_d = 1'b1;
                    end
                end
                default: pc_d = PcPlus4;
            endcase
        end
    end

    // NOTE: clocked state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge Clk or negedge PcReSetN) begin
        if (!PcReSetN) begin
            pc_q        <= RESET_VEC;
            top_q       <= '0;
            cnt_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            top_q       <= top_d;
            cnt_q       <= cnt_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef PC_ALIGN_CHK_EN
    always_ff @(posedge Clk or negedge PcReSetN) begin
        if (!PcReSetN) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`endif

    // NOTE: stack storage has no reset; a zero count makes its contents unreachable, so clearing it would only cost area.
    always_ff @(posedge Clk) begin
        if (push) begin
            ras_q[top_d] <= PcPlus4;
        end
    end

    assign PC           = pc_q;
    assign RasEmpty     = ras_empty;
    assign RasFull      = ras_full;
    assign RasUnderflow = underflow_q;

endmodule

// File: tb/tb_pc_gen_ras.sv
// Directed bench for pc_gen_ras: a vector table for single-cycle behaviour plus hand sequences
// for stack overflow/underflow, address wrap and asynchronous reset.
module tb_pc_gen_ras;

`ifdef PC_ALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    localparam logic [2:0] SEQ = 3'b000, BRA = 3'b001, JMP = 3'b010, CAL = 3'b011, RET = 3'b100;

    logic        Clk = 1'b0;
    logic        PcReSetN;
    logic        PcHold;
    logic [2:0]  PcSel;
    logic [31:0] Address;
    logic [31:0] PC;
    logic [31:0] PcPlus4;
    logic        RasEmpty, RasFull, RasUnderflow, Misalign;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        hold;
        logic [2:0]  sel;
        logic [31:0] addr;
        logic [31:0] pc;
        logic        empty;
        logic        full;
        logic        unf;
        logic        mis;
    } vec_t;

    vec_t vecs[$];

    pc_gen_ras #(.ADDR_W(32), .RESET_VEC(32'h0000_3000), .RAS_DEPTH(4)) dut (
        .Clk(Clk), .PcReSetN(PcReSetN), .PcHold(PcHold), .PcSel(PcSel), .Address(Address),
        .PC(PC), .PcPlus4(PcPlus4), .RasEmpty(RasEmpty), .RasFull(RasFull),
        .RasUnderflow(RasUnderflow), .Misalign(Misalign)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_state(input string name, input logic [31:0] pc, input logic empty,
                               input logic full, input logic unf, input logic mis);
        check({name, " PC"}, PC, pc);
        check({name, " PcPlus4"}, PcPlus4, pc + 32'd4);
        check({name, " flags{E,F,U,M}"}, {28'd0, RasEmpty, RasFull, RasUnderflow, Misalign},
              {28'd0, empty, full, unf, mis});
    endtask

    task automatic step(input logic hold, input logic [2:0] sel, input logic [31:0] addr);
        PcHold  = hold;
        PcSel   = sel;
        Address = addr;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [31:0] jmp_pc;
        PcReSetN = 1'b0;
        PcHold   = 1'b0;
        PcSel    = SEQ;
        Address  = '0;

        jmp_pc = CHK ? 32'h0000_3020 : 32'h0000_4000;
        //                hold sel  addr          pc            E  F  U  M
        vecs.push_back('{1'b0, SEQ, 32'h0,        32'h3004,     1, 0, 0, 0});
        vecs.push_back('{1'b0, SEQ, 32'h0,        32'h3008,     1, 0, 0, 0});
        vecs.push_back('{1'b0, SEQ, 32'h0,        32'h300C,     1, 0, 0, 0});
        vecs.push_back('{1'b0, SEQ, 32'h0,        32'h3010,     1, 0, 0, 0});
        vecs.push_back('{1'b0, BRA, 32'hFFFF_FFFC, 32'h3000,    1, 0, 0, 0});
        vecs.push_back('{1'b0, CAL, 32'h4000,     32'h4000,     0, 0, 0, 0});
        vecs.push_back('{1'b0, CAL, 32'h5000,     32'h5000,     0, 0, 0, 0});
        vecs.push_back('{1'b0, RET, 32'h0,        32'h4004,     0, 0, 0, 0});
        vecs.push_back('{1'b0, RET, 32'h0,        32'h3004,     1, 0, 0, 0});
        vecs.push_back('{1'b0, RET, 32'h0,        32'h3008,     1, 0, 1, 0});
        vecs.push_back('{1'b0, SEQ, 32'h0,        32'h300C,     1, 0, 0, 0});
        vecs.push_back('{1'b0, BRA, 32'h4,        32'h301C,     1, 0, 0, 0});
        vecs.push_back('{1'b0, JMP, 32'h4002,     jmp_pc,       1, 0, 0, CHK});
        vecs.push_back('{1'b0, SEQ, 32'h0,        jmp_pc + 4,   1, 0, 0, 0});
        vecs.push_back('{1'b0, JMP, 32'h7000,     32'h7000,     1, 0, 0, 0});
        vecs.push_back('{1'b0, CAL, 32'h6000,     32'h6000,     0, 0, 0, 0});
        vecs.push_back('{1'b1, CAL, 32'h8000,     32'h6000,     0, 0, 0, 0});
        vecs.push_back('{1'b1, CAL, 32'h8000,     32'h6000,     0, 0, 0, 0});
        vecs.push_back('{1'b1, RET, 32'h0,        32'h6000,     0, 0, 0, 0});
        vecs.push_back('{1'b0, RET, 32'h0,        32'h7004,     1, 0, 0, 0});
        vecs.push_back('{1'b0, 3'b101, 32'h9000,  32'h7008,     1, 0, 0, 0});
        vecs.push_back('{1'b0, 3'b111, 32'h9000,  32'h700C,     1, 0, 0, 0});
        vecs.push_back('{1'b1, RET, 32'h0,        32'h700C,     1, 0, 0, 0});
        vecs.push_back('{1'b0, RET, 32'h0,        32'h7010,     1, 0, 1, 0});
        vecs.push_back('{1'b1, RET, 32'h0,        32'h7010,     1, 0, 0, 0});

        repeat (3) @(posedge Clk);
        #1;
        check_state("reset", 32'h3000, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        PcReSetN = 1'b1;
        check_state("after release", 32'h3000, 1'b1, 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            step(vecs[i].hold, vecs[i].sel, vecs[i].addr);
            check_state($sformatf("vec[%0d]", i), vecs[i].pc, vecs[i].empty, vecs[i].full,
                        vecs[i].unf, vecs[i].mis);
        end

        // Overflow: five calls from 0x7010 push R1..R5; the oldest (R1) is overwritten.
        step(1'b0, CAL, 32'h1000); check_state("ovf call1", 32'h1000, 0, 0, 0, 0);
        step(1'b0, CAL, 32'h2000); check_state("ovf call2", 32'h2000, 0, 0, 0, 0);
        step(1'b0, CAL, 32'h3000); check_state("ovf call3", 32'h3000, 0, 0, 0, 0);
        step(1'b0, CAL, 32'h4000); check_state("ovf call4", 32'h4000, 0, 1, 0, 0);
        step(1'b0, CAL, 32'h5000); check_state("ovf call5", 32'h5000, 0, 1, 0, 0);
        step(1'b0, RET, 32'h0);    check_state("ovf ret R5", 32'h4004, 0, 0, 0, 0);
        step(1'b0, RET, 32'h0);    check_state("ovf ret R4", 32'h3004, 0, 0, 0, 0);
        step(1'b0, RET, 32'h0);    check_state("ovf ret R3", 32'h2004, 0, 0, 0, 0);
        step(1'b0, RET, 32'h0);    check_state("ovf ret R2", 32'h1004, 1, 0, 0, 0);
        step(1'b0, RET, 32'h0);    check_state("ovf ret empty", 32'h1008, 1, 0, 1, 0);
        step(1'b0, SEQ, 32'h0);    check_state("ovf pulse end", 32'h100C, 1, 0, 0, 0);

        // Wrap at the top of the address space.
        step(1'b0, JMP, 32'hFFFF_FFFC);
        check("wrap PC", PC, 32'hFFFF_FFFC);
        check("wrap PcPlus4", PcPlus4, 32'h0000_0000);
        step(1'b0, SEQ, 32'h0);
        check("wrap seq PC", PC, 32'h0000_0000);

        // Asynchronous reset mid-cycle with two entries stacked.
        step(1'b0, CAL, 32'h4000);
        step(1'b0, CAL, 32'h5000);
        check_state("pre-reset", 32'h5000, 0, 0, 0, 0);
        PcSel = SEQ;
        #2;
        PcReSetN = 1'b0;
        #1;
        check_state("async reset", 32'h3000, 1, 0, 0, 0);
        @(negedge Clk);
        PcReSetN = 1'b1;
        step(1'b0, SEQ, 32'h0);    check_state("post-reset seq", 32'h3004, 1, 0, 0, 0);
        step(1'b0, RET, 32'h0);    check_state("post-reset ret", 32'h3008, 1, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
